pipe_ctrl_chain: RTL and testbench

PIPE_CTRL_CHAIN -- requirements
Module: pipe_ctrl_chain

---
 rtl/pipe_ctrl_chain_pkg.sv | 25 ++
 rtl/pipe_ctrl_chain_stage.sv | 43 ++++
 rtl/pipe_ctrl_chain.sv | 77 +++++++
 tb/tb_pipe_ctrl_chain.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared definitions for the post-decode control pipeline: bundle layout and
// write-back select encoding.
package pipe_ctrl_chain_pkg;

  localparam int CTRL_W_DEF = 10;

  // Bit offsets of the fields inside one control bundle.
  localparam int F_REG_WR   = 0;
  localparam int F_WR_EN    = 1;
  localparam int F_RD_EN    = 2;
  localparam int F_CSR_RD   = 3;
  localparam int F_CSR_WR   = 4;
  localparam int F_IS_MRET  = 5;
  localparam int F_WB_SEL   = 6;
  localparam int WB_SEL_W   = 2;
  localparam int F_SPARE    = 8;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_CSR = 2'd2,
    WB_PC4 = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/pipe_ctrl_chain_stage.sv
// One control stage: hold, bubble insertion, flush and valid gating of the
// stored bundle.
module pipe_ctrl_stage
  import pipe_ctrl_chain_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              prev_hold,
  input  logic              flush,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic              load_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic              q_valid,
  output logic [CTRL_W-1:0] gated_ctrl
);

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; the async reset clears the whole bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
    end else if (!hold) begin
      if (prev_hold) begin
        // Upstream is frozen while this stage drains: emit a bubble.
        q_valid <= 1'b0;
        q_ctrl  <= '0;
      end else begin
        q_valid <= load_valid;
        q_ctrl  <= load_valid ? load_ctrl : '0;
      end
    end
  end

  assign gated_ctrl = q_ctrl & {CTRL_W{q_valid}};

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Chain of DEPTH control stages after decode with stall/flush handling and a
// retire counter on the last stage.
module pipe_ctrl_chain
  import pipe_ctrl_chain_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CTRL_W-1:0]       ctrl_in,
  input  logic                    valid_in,
  input  logic [DEPTH-1:0]        stall_vec,
  input  logic [DEPTH-1:0]        flush_vec,
  output logic [DEPTH*CTRL_W-1:0] stage_ctrl,
  output logic [DEPTH-1:0]        stage_valid,
  output logic                    retire,
  output logic [CNT_W-1:0]        retire_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DEPTH-1:0]  hold;
  logic [DEPTH-1:0]  st_valid;
  logic [CTRL_W-1:0] st_ctrl [DEPTH];

  // An older stall freezes every younger stage behind it.
  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    hold = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hold[i] = |(stall_vec >> i);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic              prev_hold;
    logic [CTRL_W-1:0] load_ctrl;
    logic              load_valid;

    if (g == 0) begin : g_head
      assign prev_hold  = 1'b0;
      assign load_ctrl  = ctrl_in;
      assign load_valid = valid_in;
    end else begin : g_body
      assign prev_hold  = hold[g-1];
      assign load_ctrl  = st_ctrl[g-1];
      assign load_valid = st_valid[g-1];
    end

    pipe_ctrl_stage #(.CTRL_W(CTRL_W)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .hold       (hold[g]),
      .prev_hold  (prev_hold),
      .flush      (flush_vec[g]),
      .load_ctrl  (load_ctrl),
      .load_valid (load_valid),
      .q_ctrl     (st_ctrl[g]),
      .q_valid    (st_valid[g]),
      .gated_ctrl (stage_ctrl[g*CTRL_W +: CTRL_W])
    );
  end

  assign stage_valid = st_valid;
  assign retire      = st_valid[DEPTH-1] & ~hold[DEPTH-1] & ~flush_vec[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Bench for pipe_ctrl_chain: a DEPTH=3/CNT_W=4 and a DEPTH=2/CNT_W=32 instance
// share one stimulus stream and are checked against a slot-list model.
module tb_pipe_ctrl_chain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  ctrl_in;
  logic        valid_in;
  logic [2:0]  stall_vec;
  logic [2:0]  flush_vec;

  logic [29:0] sc_a;
  logic [2:0]  sv_a;
  logic        ret_a;
  logic [3:0]  cnt_a;
  logic [19:0] sc_b;
  logic [1:0]  sv_b;
  logic        ret_b;
  logic [31:0] cnt_b;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_chain #(.CTRL_W(10), .DEPTH(3), .CNT_W(4)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl_in     (ctrl_in),
    .valid_in    (valid_in),
    .stall_vec   (stall_vec),
    .flush_vec   (flush_vec),
    .stage_ctrl  (sc_a),
    .stage_valid (sv_a),
    .retire      (ret_a),
    .retire_cnt  (cnt_a)
  );

  pipe_ctrl_chain #(.CTRL_W(10), .DEPTH(2), .CNT_W(32)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl_in     (ctrl_in),
    .valid_in    (valid_in),
    .stall_vec   (stall_vec[1:0]),
    .flush_vec   (flush_vec[1:0]),
    .stage_ctrl  (sc_b),
    .stage_valid (sv_b),
    .retire      (ret_b),
    .retire_cnt  (cnt_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per instance, a list of slots, oldest last.
  bit         m_valid [2][8];
  logic [9:0] m_ctrl  [2][8];
  logic [31:0] m_cnt  [2];

  function automatic bit frozen(input int depth, input int i);
    bit f = 1'b0;
    for (int j = i; j < depth; j++) f |= stall_vec[j];
    return f;
  endfunction

  function automatic bit m_retire(input int d, input int depth);
    return m_valid[d][depth-1] && !frozen(depth, depth-1) && !flush_vec[depth-1];
  endfunction

  task automatic m_step(input int d, input int depth);
    bit         nv [8];
    logic [9:0] nc [8];
    for (int i = 0; i < depth; i++) begin
      if (flush_vec[i]) begin
        nv[i] = 1'b0; nc[i] = '0;
      end else if (frozen(depth, i)) begin
        nv[i] = m_valid[d][i]; nc[i] = m_ctrl[d][i];
      end else if (i == 0) begin
        nv[i] = valid_in; nc[i] = valid_in ? ctrl_in : 10'h0;
      end else if (frozen(depth, i-1)) begin
        nv[i] = 1'b0; nc[i] = '0;
      end else begin
        nv[i] = m_valid[d][i-1]; nc[i] = m_ctrl[d][i-1];
      end
    end
    if (m_retire(d, depth)) m_cnt[d] = m_cnt[d] + 1;
    for (int i = 0; i < depth; i++) begin
      m_valid[d][i] = nv[i];
      m_ctrl[d][i]  = nc[i];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] = '0;
        for (int i = 0; i < 8; i++) begin
          m_valid[d][i] = 1'b0;
          m_ctrl[d][i]  = '0;
        end
      end
    end else begin
      m_step(0, 3);
      m_step(1, 2);
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      logic [29:0] e_sc_a;
      logic [2:0]  e_sv_a;
      logic [19:0] e_sc_b;
      logic [1:0]  e_sv_b;
      for (int i = 0; i < 3; i++) begin
        e_sv_a[i]          = m_valid[0][i];
        e_sc_a[i*10 +: 10] = m_valid[0][i] ? m_ctrl[0][i] : 10'h0;
      end
      for (int i = 0; i < 2; i++) begin
        e_sv_b[i]          = m_valid[1][i];
        e_sc_b[i*10 +: 10] = m_valid[1][i] ? m_ctrl[1][i] : 10'h0;
      end
      check("a.stage_ctrl",  64'(sc_a),  64'(e_sc_a));
      check("a.stage_valid", 64'(sv_a),  64'(e_sv_a));
      check("a.retire",      64'(ret_a), 64'(m_retire(0, 3)));
      check("a.retire_cnt",  64'(cnt_a), 64'(m_cnt[0][3:0]));
      check("b.stage_ctrl",  64'(sc_b),  64'(e_sc_b));
      check("b.stage_valid", 64'(sv_b),  64'(e_sv_b));
      check("b.retire",      64'(ret_b), 64'(m_retire(1, 2)));
      check("b.retire_cnt",  64'(cnt_b), 64'(m_cnt[1]));
    end
  end

  task automatic set_in(input logic [9:0] c, input logic v, input logic [2:0] s, input logic [2:0] f);
    ctrl_in = c; valid_in = v; stall_vec = s; flush_vec = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [9:0] c;
    logic       v;
    logic [2:0] s;
    logic [2:0] f;
  } vec_t;

  vec_t mix [10];

  initial begin
    mix[0] = '{10'h011, 1'b1, 3'b000, 3'b000};
    mix[1] = '{10'h022, 1'b1, 3'b000, 3'b000};
    mix[2] = '{10'h033, 1'b1, 3'b100, 3'b000};
    mix[3] = '{10'h044, 1'b1, 3'b001, 3'b000};
    mix[4] = '{10'h055, 1'b1, 3'b000, 3'b010};
    mix[5] = '{10'h066, 1'b0, 3'b000, 3'b100};
    mix[6] = '{10'h077, 1'b1, 3'b100, 3'b100};
    mix[7] = '{10'h088, 1'b1, 3'b000, 3'b000};
    mix[8] = '{10'h099, 1'b1, 3'b010, 3'b001};
    mix[9] = '{10'h0AA, 1'b1, 3'b000, 3'b000};

    rst_n = 1'b0;
    set_in(10'h0, 1'b0, 3'b000, 3'b000);
    #11;
    check("reset.valid_a", 64'(sv_a),  64'h0);
    check("reset.ctrl_a",  64'(sc_a),  64'h0);
    check("reset.cnt_a",   64'(cnt_a), 64'h0);
    check("reset.retire_a", 64'(ret_a), 64'h0);
    @(negedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Two-stage latency and steady retire.
    set_in(10'h2A5, 1'b1, 3'b000, 3'b000);
    tick(); tick();
    check("lat.b_stage1", 64'(sc_b[19:10]), 64'h2A5);
    check("lat.b_valid",  64'(sv_b),        64'h3);
    check("lat.b_retire", 64'(ret_b),       64'h1);
    tick(); tick(); tick();
    check("lat.b_cnt", 64'(cnt_b), 64'd3);
    check("lat.a_cnt", 64'(cnt_a), 64'd2);

    // Invalid entry with all-ones control must stay dark in every stage.
    set_in(10'h3FF, 1'b0, 3'b000, 3'b000);
    tick();
    check("inv.s0_ctrl", 64'(sc_a[9:0]),   64'h0);
    check("inv.valid1",  64'(sv_a),        64'h6);
    tick();
    check("inv.s1_ctrl", 64'(sc_a[19:10]), 64'h0);
    tick();
    check("inv.s2_ctrl", 64'(sc_a[29:20]), 64'h0);
    check("inv.valid3",  64'(sv_a),        64'h0);

    set_in(10'h101, 1'b1, 3'b000, 3'b000); tick();
    set_in(10'h102, 1'b1, 3'b000, 3'b000); tick();
    set_in(10'h103, 1'b1, 3'b000, 3'b000); tick();
    check("fill.ctrl", 64'(sc_a), 64'({10'h101, 10'h102, 10'h103}));

    // Middle stall: stages 0,1 frozen, stage 2 drains to a bubble.
    set_in(10'h104, 1'b1, 3'b010, 3'b000);
    check("stall.retire_now", 64'(ret_a), 64'h1);
    tick();
    check("stall.valid",  64'(sv_a),        64'h3);
    check("stall.s2",     64'(sc_a[29:20]), 64'h0);
    check("stall.s1_s0",  64'(sc_a[19:0]),  64'({10'h102, 10'h103}));
    set_in(10'h105, 1'b1, 3'b000, 3'b000);
    check("stall.retire_next", 64'(ret_a), 64'h0);
    tick();

    // Flush of held stages 0,1 while stage 2 retires.
    set_in(10'h106, 1'b1, 3'b011, 3'b011);
    check("flush.retire", 64'(ret_a), 64'h1);
    tick();
    check("flush.valid", 64'(sv_a), 64'h0);
    check("flush.ctrl",  64'(sc_a), 64'h0);

    // Run until the 4-bit counter reaches all-ones, then one more retire wraps it.
    begin
      int k = 0;
      while (k < 40 && cnt_a !== 4'hF) begin
        set_in(10'h200 + 10'(k), 1'b1, 3'b000, 3'b000);
        tick();
        k++;
      end
    end
    check("wrap.reach_F", 64'(cnt_a), 64'hF);
    check("wrap.retire",  64'(ret_a), 64'h1);
    tick();
    check("wrap.zero",    64'(cnt_a), 64'h0);

    // Asynchronous reset mid-stream, no clock edge in between.
    rst_n = 1'b0;
    #1;
    check("areset.valid_a", 64'(sv_a),  64'h0);
    check("areset.ctrl_a",  64'(sc_a),  64'h0);
    check("areset.cnt_a",   64'(cnt_a), 64'h0);
    check("areset.valid_b", 64'(sv_b),  64'h0);
    check("areset.ctrl_b",  64'(sc_b),  64'h0);
    check("areset.cnt_b",   64'(cnt_b), 64'h0);
    check("areset.retire",  64'(ret_a), 64'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    foreach (mix[i]) begin
      set_in(mix[i].c, mix[i].v, mix[i].s, mix[i].f);
      tick();
    end

    // Everything stalled and flushed: no retire, all stages empty.
    set_in(10'h3C3, 1'b1, 3'b111, 3'b111);
    check("allones.retire", 64'(ret_a), 64'h0);
    check("allones.retire_b", 64'(ret_b), 64'h0);
    tick();
    check("allones.valid", 64'(sv_a), 64'h0);
    set_in(10'h0, 1'b0, 3'b000, 3'b000);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
